// File: rtl/sbox_share_ctrl.sv
// Folded SubBytes/SubWord scheduler sharing LANES sbox instances.
// Optional macro SBOX_SHARE_RR_EN selects round-robin arbitration.
module sbox_share_ctrl #(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               st_valid,
  output logic               st_ready,
  input  logic [127:0]       st_data,
  output logic               st_done,
  output logic [127:0]       st_result,
  input  logic               kw_valid,
  output logic               kw_ready,
  input  logic [31:0]        kw_data,
  output logic               kw_done,
  output logic [31:0]        kw_result,
  output logic [8*LANES-1:0] sb_in,
  input  logic [8*LANES-1:0] sb_out,
  output logic               busy
);

  localparam int P  = 16 / LANES;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int W  = 8 * LANES;

  typedef enum logic [1:0] {
    IDLE,
    ST_RUN,
    KW_RUN
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [PW-1:0]  p;
  logic [127:0]   buffer;
  logic           idle;
  logic           st_acc;
  logic           kw_acc;
  logic           last_pass;

  assign idle      = (state == IDLE);
  assign busy      = !idle;
  assign last_pass = (p == PW'(P - 1));
  assign kw_acc    = kw_valid && kw_ready;
  assign st_acc    = st_valid && st_ready && !kw_acc;

`ifdef SBOX_SHARE_RR_EN
  typedef enum logic {
    G_ST,
    G_KW
  } grant_t;

  grant_t last_grant;

  // Remember who was served last so a conflict goes to the other side.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= G_ST;
    end else if (kw_acc) begin
      last_grant <= G_KW;
    end else if (st_acc) begin
      last_grant <= G_ST;
    end
  end

  // Round-robin readies: yield only when the other side waits and is due.
  always_comb begin
    kw_ready = !rst && idle && !(st_valid && last_grant == G_KW);
    st_ready = !rst && idle && !(kw_valid && last_grant == G_ST);
  end
`else
  // Fixed priority readies: a pending key word blocks the state job.
  always_comb begin
    kw_ready = !rst && idle;
    st_ready = !rst && idle && !kw_valid;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: jobs start only from IDLE and always return to it.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (kw_acc) begin
          state_nx = KW_RUN;
        end else if (st_acc) begin
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_pass) begin
          state_nx = IDLE;
        end
      end
      KW_RUN: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Sbox bank feed: current state slice or key word, zero when idle.
  always_comb begin
    sb_in = '0;
    if (!rst) begin
      unique case (state)
        ST_RUN: sb_in = buffer[127 - W*int'(p) -: W];
        KW_RUN: sb_in[W-1 -: 32] = buffer[127 -: 32];
        default: sb_in = '0;
      endcase
    end
  end

  // Capture inputs at accept, step passes, latch results and done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      p         <= '0;
      buffer    <= '0;
      st_result <= '0;
      kw_result <= '0;
      st_done   <= 1'b0;
      kw_done   <= 1'b0;
    end else begin
      st_done <= 1'b0;
      kw_done <= 1'b0;
      if (kw_acc) begin
        buffer[127 -: 32] <= kw_data;
      end else if (st_acc) begin
        buffer <= st_data;
      end
      if (state == ST_RUN) begin
        st_result[127 - W*int'(p) -: W] <= sb_out;
        if (last_pass) begin
          p       <= '0;
          st_done <= 1'b1;
        end else begin
          p <= p + 1'b1;
        end
      end
      if (state == KW_RUN) begin
        kw_result <= sb_out[W-1 -: 32];
        kw_done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Directed bench for sbox_share_ctrl with real AES sbox lanes.
// Covers LANES=4 and LANES=16 builds side by side.
module tb_sbox_share_ctrl;

  localparam logic [7:0] SB [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         st_valid = 1'b0;
  logic         st_ready;
  logic [127:0] st_data = '0;
  logic         st_done;
  logic [127:0] st_result;
  logic         kw_valid = 1'b0;
  logic         kw_ready;
  logic [31:0]  kw_data = '0;
  logic         kw_done;
  logic [31:0]  kw_result;
  logic [31:0]  sb_in;
  logic [31:0]  sb_out;
  logic         busy;

  logic         h_st_valid = 1'b0;
  logic         h_st_ready;
  logic [127:0] h_st_data = '0;
  logic         h_st_done;
  logic [127:0] h_st_result;
  logic         h_kw_ready;
  logic         h_kw_done;
  logic [31:0]  h_kw_result;
  logic [127:0] h_sb_in;
  logic [127:0] h_sb_out;
  logic         h_busy;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  always_comb begin
    sb_out = '0;
    for (int i = 0; i < 4; i++) sb_out[8*i +: 8] = SB[sb_in[8*i +: 8]];
  end

  always_comb begin
    h_sb_out = '0;
    for (int i = 0; i < 16; i++) h_sb_out[8*i +: 8] = SB[h_sb_in[8*i +: 8]];
  end

  sbox_share_ctrl #(.LANES(4)) dut4 (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
    .st_done(st_done), .st_result(st_result),
    .kw_valid(kw_valid), .kw_ready(kw_ready), .kw_data(kw_data),
    .kw_done(kw_done), .kw_result(kw_result),
    .sb_in(sb_in), .sb_out(sb_out), .busy(busy)
  );

  sbox_share_ctrl #(.LANES(16)) dut16 (
    .clk(clk), .rst(rst),
    .st_valid(h_st_valid), .st_ready(h_st_ready), .st_data(h_st_data),
    .st_done(h_st_done), .st_result(h_st_result),
    .kw_valid(1'b0), .kw_ready(h_kw_ready), .kw_data(32'h0),
    .kw_done(h_kw_done), .kw_result(h_kw_result),
    .sb_in(h_sb_in), .sb_out(h_sb_out), .busy(h_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    st_valid = 1'b1;
    kw_valid = 1'b1;
    tick();
    tick();
    checks++; if (st_ready !== 1'b0) $display("FAIL rst_st_ready got %0b want 0", st_ready); else passed++;
    checks++; if (kw_ready !== 1'b0) $display("FAIL rst_kw_ready got %0b want 0", kw_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy); else passed++;
    checks++; if ({st_done, kw_done} !== 2'b00) $display("FAIL rst_done got %b want 00", {st_done, kw_done}); else passed++;
    checks++; if (st_result !== 128'h0) $display("FAIL rst_st_result got %h want 0", st_result); else passed++;
    checks++; if (kw_result !== 32'h0) $display("FAIL rst_kw_result got %h want 0", kw_result); else passed++;
    checks++; if (sb_in !== 32'h0) $display("FAIL rst_sb_in got %h want 0", sb_in); else passed++;
    checks++; if (h_st_ready !== 1'b0) $display("FAIL rst_h_st_ready got %0b want 0", h_st_ready); else passed++;
    st_valid = 1'b0;
    kw_valid = 1'b0;
    rst = 1'b0;
    tick();
    checks++; if ({st_ready, kw_ready} !== 2'b11) $display("FAIL post_rst_ready got %b want 11", {st_ready, kw_ready}); else passed++;
  endtask

  task automatic test_state_job();
    st_valid = 1'b1;
    st_data = 128'h0;
    #1;
    checks++; if (st_ready !== 1'b1) $display("FAIL st_accept_ready got %0b want 1", st_ready); else passed++;
    tick();
    st_valid = 1'b0;
    st_data = {16{8'hAA}};
    for (int k = 1; k <= 4; k++) begin
      checks++; if ({busy, st_done, st_ready} !== 3'b100) $display("FAIL st_run_c%0d busy/done/ready got %b want 100", k, {busy, st_done, st_ready}); else passed++;
      tick();
    end
    checks++; if (st_done !== 1'b1) $display("FAIL st_done_t5 got %0b want 1", st_done); else passed++;
    checks++; if (st_result !== {16{8'h63}}) $display("FAIL st_result_zero got %h want %h", st_result, {16{8'h63}}); else passed++;
    checks++; if ({busy, st_ready} !== 2'b01) $display("FAIL st_end busy/ready got %b want 01", {busy, st_ready}); else passed++;
    tick();
    checks++; if (st_done !== 1'b0) $display("FAIL st_done_pulse got %0b want 0", st_done); else passed++;
  endtask

  task automatic test_key_word();
    kw_valid = 1'b1;
    kw_data = 32'h000153FF;
    tick();
    kw_valid = 1'b0;
    kw_data = 32'h0;
    checks++; if (sb_in !== 32'h000153FF) $display("FAIL kw_sb_in got %h want 000153ff", sb_in); else passed++;
    checks++; if ({busy, kw_done} !== 2'b10) $display("FAIL kw_t1 busy/done got %b want 10", {busy, kw_done}); else passed++;
    tick();
    checks++; if (kw_done !== 1'b1) $display("FAIL kw_done_t2 got %0b want 1", kw_done); else passed++;
    checks++; if (kw_result !== 32'h637CED16) $display("FAIL kw_result got %h want 637ced16", kw_result); else passed++;
    checks++; if (st_result !== {16{8'h63}}) $display("FAIL kw_st_result_kept got %h want %h", st_result, {16{8'h63}}); else passed++;
    checks++; if ({st_ready, kw_ready} !== 2'b11) $display("FAIL kw_end_ready got %b want 11", {st_ready, kw_ready}); else passed++;
  endtask

  task automatic test_conflict();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    kw_valid = 1'b1;
    kw_data = 32'h01010101;
    st_valid = 1'b1;
    st_data = {16{8'h53}};
    #1;
    checks++; if ({kw_ready, st_ready} !== 2'b10) $display("FAIL cf_grant kw/st ready got %b want 10", {kw_ready, st_ready}); else passed++;
    tick();
    kw_valid = 1'b0;
    checks++; if (st_ready !== 1'b0) $display("FAIL cf_kw_run_st_ready got %0b want 0", st_ready); else passed++;
    tick();
    checks++; if (kw_done !== 1'b1) $display("FAIL cf_kw_done got %0b want 1", kw_done); else passed++;
    checks++; if (kw_result !== 32'h7C7C7C7C) $display("FAIL cf_kw_result got %h want 7c7c7c7c", kw_result); else passed++;
`ifdef SBOX_SHARE_RR_EN
    kw_valid = 1'b1;
    #1;
    checks++; if ({kw_ready, st_ready} !== 2'b01) $display("FAIL cf_rr_grant kw/st ready got %b want 01", {kw_ready, st_ready}); else passed++;
`else
    checks++; if (st_ready !== 1'b1) $display("FAIL cf_st_ready got %0b want 1", st_ready); else passed++;
`endif
    tick();
    kw_valid = 1'b0;
    st_valid = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (st_done !== 1'b0) $display("FAIL cf_st_early got %0b want 0", st_done); else passed++;
    tick();
    checks++; if (st_done !== 1'b1) $display("FAIL cf_st_done got %0b want 1", st_done); else passed++;
    checks++; if (st_result !== {16{8'hED}}) $display("FAIL cf_st_result got %h want %h", st_result, {16{8'hED}}); else passed++;
  endtask

  task automatic test_reset_mid();
    st_valid = 1'b1;
    st_data = 128'h000102030405060708090A0B0C0D0E0F;
    tick();
    st_valid = 1'b0;
    tick();
    tick();
    checks++; if (sb_in !== 32'h08090A0B) $display("FAIL mid_sb_in_p2 got %h want 08090a0b", sb_in); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (st_done !== 1'b0) $display("FAIL mid_no_done got %0b want 0", st_done); else passed++;
    checks++; if (st_result !== 128'h0) $display("FAIL mid_result_clr got %h want 0", st_result); else passed++;
    checks++; if ({st_ready, busy} !== 2'b10) $display("FAIL mid_idle ready/busy got %b want 10", {st_ready, busy}); else passed++;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (st_done !== 1'b0) $display("FAIL mid_late_done c%0d got %0b want 0", k, st_done); else passed++;
    end
    st_valid = 1'b1;
    st_data = {16{8'h01}};
    tick();
    st_valid = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    checks++; if (st_done !== 1'b1) $display("FAIL mid_next_done got %0b want 1", st_done); else passed++;
    checks++; if (st_result !== {16{8'h7C}}) $display("FAIL mid_next_result got %h want %h", st_result, {16{8'h7C}}); else passed++;
  endtask

  task automatic test_back_to_back();
    st_valid = 1'b1;
    st_data = 128'h0;
    tick();
    st_data = {16{8'hFF}};
    for (int k = 1; k < 5; k++) begin
      checks++; if (st_ready !== 1'b0) $display("FAIL b2b_ready_c%0d got %0b want 0", k, st_ready); else passed++;
      tick();
    end
    checks++; if (st_done !== 1'b1) $display("FAIL b2b_done1 got %0b want 1", st_done); else passed++;
    checks++; if (st_result !== {16{8'h63}}) $display("FAIL b2b_result1 got %h want %h", st_result, {16{8'h63}}); else passed++;
    checks++; if (st_ready !== 1'b1) $display("FAIL b2b_reaccept got %0b want 1", st_ready); else passed++;
    tick();
    st_valid = 1'b0;
    for (int k = 6; k < 10; k++) begin
      checks++; if (st_done !== 1'b0) $display("FAIL b2b_gap_c%0d got %0b want 0", k, st_done); else passed++;
      tick();
    end
    checks++; if (st_done !== 1'b1) $display("FAIL b2b_done2 got %0b want 1", st_done); else passed++;
    checks++; if (st_result !== {16{8'h16}}) $display("FAIL b2b_result2 got %h want %h", st_result, {16{8'h16}}); else passed++;
  endtask

  task automatic test_lanes16();
    h_st_valid = 1'b1;
    h_st_data = 128'h0;
    #1;
    checks++; if (h_st_ready !== 1'b1) $display("FAIL l16_ready got %0b want 1", h_st_ready); else passed++;
    tick();
    h_st_valid = 1'b0;
    checks++; if ({h_busy, h_st_done} !== 2'b10) $display("FAIL l16_t1 busy/done got %b want 10", {h_busy, h_st_done}); else passed++;
    tick();
    checks++; if (h_st_done !== 1'b1) $display("FAIL l16_done_t2 got %0b want 1", h_st_done); else passed++;
    checks++; if (h_st_result !== {16{8'h63}}) $display("FAIL l16_result got %h want %h", h_st_result, {16{8'h63}}); else passed++;
    checks++; if ({h_busy, h_st_ready} !== 2'b01) $display("FAIL l16_end busy/ready got %b want 01", {h_busy, h_st_ready}); else passed++;
  endtask

  initial begin
    test_reset();
    test_state_job();
    test_key_word();
    test_conflict();
    test_reset_mid();
    test_back_to_back();
    test_lanes16();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sbox_share_ctrl.md
Name: sbox_share_ctrl

Overview:
- Folded substitution scheduler for the AES core.
- Shares a small bank of LANES external sbox instances between two requesters:
  - the round datapath, which needs a full 128-bit SubBytes;
  - the key expansion, which needs a 32-bit SubWord.
- Arbitrates between them, sequences the 128-bit state through the sbox bank in 16/LANES passes, and returns results with valid/ready-in, done-pulse-out handshakes.

Parameters:
- LANES, 4, number of shared sbox instances; legal values 4, 8, 16; passes per state job P = 16/LANES.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- st_valid  in  1  state job request.
- st_ready  out  1  state job accepted when st_valid && st_ready.
- st_data  in  128  state to substitute; byte 0 = bits [127:120].
- st_done  out  1  one-cycle pulse when st_result is updated.
- st_result  out  128  substituted state; held until the next state accept.
- kw_valid  in  1  key-word request.
- kw_ready  out  1  key-word accept.
- kw_data  in  32  word to substitute; byte 0 = bits [31:24].
- kw_done  out  1  one-cycle pulse when kw_result is updated.
- kw_result  out  32  substituted word; held until the next key accept.
- sb_in  out  8*LANES  bytes driven to the sbox bank; lane 0 = MSB byte.
- sb_out  in  8*LANES  sbox bank results, combinational, same cycle.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset, synchronous active-high:
  - state = IDLE;
  - st_result, kw_result, sb_in = 0;
  - st_done, kw_done, busy = 0;
  - st_ready, kw_ready = 0 while rst is high.
- States:
  - IDLE: both readies may be high; sb_in = 0.
  - ST_RUN: pass counter p runs 0..P-1.
  - KW_RUN: single cycle.
- Readiness and arbitration in IDLE:
  - kw_ready = (state==IDLE).
  - st_ready = (state==IDLE) && !kw_valid.
  - Fixed priority: key beats state. Non-preemptive; no accepts outside IDLE.
- Accept:
  - Data is captured into an internal buffer.
  - State job: IDLE -> ST_RUN, p = 0.
  - Key job: IDLE -> KW_RUN.
  - Both valid in the same IDLE cycle: only one job is accepted; the other requester's ready stays low that cycle.
- ST_RUN pass p:
  - sb_in = buffer bytes [8*LANES*p .. 8*LANES*(p+1)-1], counted from the MSB byte.
  - sb_out is captured into the matching st_result slice at the clock edge.
  - At the edge ending pass P-1: st_done <= 1 for one cycle; state -> IDLE; p wraps to 0.
  - Intermediate slices of st_result may update during the job. Consumers use the result only on or after st_done.
- KW_RUN:
  - Lanes 0..3 = kw_data bytes; lanes >= 4 are driven 0.
  - sb_out[8*LANES-1 -: 32] is captured into kw_result.
  - kw_done <= 1 for one cycle; state -> IDLE.
- Latency, with accept in cycle T:
  - st_done is high in cycle T+P+1 (T+5 for LANES=4, T+2 for LANES=16).
  - kw_done is high in cycle T+2.
  - The readies re-assert in the same cycle as the done pulse, giving back-to-back throughput of one job per P+1 cycles.
- Input stability: data is sampled only at accept; input changes after accept have no effect on a running job.
- Reset mid-job:
  - The job is aborted; no done pulse is generated.
  - Results are cleared to 0; the counter is cleared.
  - The FSM is in IDLE on the first cycle after reset deasserts.
- Widths: p is clog2(P) bits, minimum 1 bit. For LANES=16, ST_RUN lasts exactly one cycle.

Optional Feature:
- Macro: SBOX_SHARE_RR_EN.
- Defined: round-robin arbitration.
  - A last_grant flop records the most recently accepted requester; its reset value is state.
  - On a conflict, the requester not last granted wins.
  - Readies: kw_ready = IDLE && !(st_valid && last_grant==KW); st_ready = IDLE && !(kw_valid && last_grant==ST).
  - When there is no conflict, the sole requester is accepted.
- Undefined: fixed key-over-state priority as above. Key requests can starve state requests if asserted continuously.

Test Plan:
- LANES=4, bench wired to 4 real sbox instances. st_data=128'h0 accepted at T -> st_done high only at T+5; st_result = 128'h6363...63; busy high T+1..T+4.
- kw_data=32'h000153FF -> kw_done at T+2; kw_result = 32'h637CED16; st_result unchanged.
- kw_valid and st_valid asserted together with the state word all 8'h53:
  - key accepted first; st_ready low in that cycle;
  - state job accepted in the cycle of kw_done;
  - st_result = all 8'hED.
  - With SBOX_SHARE_RR_EN defined: a second simultaneous conflict grants state.
- rst pulsed in pass p=2 of a state job -> no st_done; st_result = 0; st_ready high the cycle after rst drops; a following job completes correctly.
- Back-to-back state jobs 128'h0 then all 8'hFF, with valid held high -> second accept in the first job's done cycle; results 6363..63 then 1616..16, done pulses 5 cycles apart.
- Rerun the first scenario with LANES=16 -> st_done at T+2.
